// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns engine: mixes LANES columns per cycle across an NB-column state.
// Define INV_MIX_EN to build the InvMixColumns datapath selected by in_inverse.
module mix_columns_engine #(
    parameter int NB    = 4,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inverse,
    input  logic [32*NB-1:0]  in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_state,
    output logic              busy
);
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [32*NB-1:0] state_reg;
    logic [CW-1:0]    col_idx;
    logic             last_group;
    logic [31:0]      mixed [LANES];

    generate
        if (LANES < 1 || (NB % LANES) != 0) begin : g_bad_lanes
            $error("mix_columns_engine: LANES must divide NB");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Row 0 lives in the most significant byte of each 32-bit column.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
        for (int r = 0; r < 4; r++)
            res[31-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                             ^ a[(r+2)%4] ^ a[(r+3)%4];
        return res;
    endfunction

`ifdef INV_MIX_EN
    logic mode;

    // 9, b, d and e are built from the x2/x4/x8 doubling chain of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++)
            res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
        return res;
    endfunction
`else
    logic unused_inverse;
    assign unused_inverse = in_inverse;
`endif

    assign last_group = (int'(col_idx) + LANES == NB);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            mixed[l] = mix_fwd(state_reg[32*(int'(col_idx)+l) +: 32]);
`ifdef INV_MIX_EN
            if (mode) mixed[l] = mix_inv(state_reg[32*(int'(col_idx)+l) +: 32]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)   state_d = CALC;
            CALC:    if (last_group) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
            col_idx   <= '0;
`ifdef INV_MIX_EN
            mode      <= 1'b0;
`endif
        end else if (state_q == IDLE && in_valid) begin
            state_reg <= in_state;
            col_idx   <= '0;
`ifdef INV_MIX_EN
            mode      <= in_inverse;
`endif
        end else if (state_q == CALC) begin
            for (int l = 0; l < LANES; l++)
                state_reg[32*(int'(col_idx)+l) +: 32] <= mixed[l];
            col_idx <= last_group ? '0 : col_idx + CW'(LANES);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = state_reg;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench for mix_columns_engine: directed AES vectors, random states vs. a GF(2^8) matrix model.
// Honours INV_MIX_EN the same way the design does.
module tb_mix_columns_engine;
    localparam int NB = 4;
`ifdef INV_MIX_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_inverse, out_ready;
    logic          in_ready, out_valid, busy;
    logic [127:0]  in_state, out_state;

    logic          w_in_valid, w_in_inverse, w_out_ready;
    logic          w_in_ready, w_out_valid, w_busy;
    logic [127:0]  w_in_state, w_out_state;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mix_columns_engine #(.NB(NB), .LANES(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );

    mix_columns_engine #(.NB(NB), .LANES(4)) dut_wide (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inverse(w_in_inverse), .in_state(w_in_state),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_state(w_out_state), .busy(w_busy)
    );

    // Generic shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*c+31-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o = o ^ gf_mul(coef[k], a[(r+k)%4]);
                res[32*c+31-8*r -: 8] = o;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a state for one edge, then scramble the inputs to prove they were latched.
    task automatic accept(input logic [127:0] s, input logic inv);
        check_bit("in_ready_before_accept", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_state   = s;
        in_inverse = inv;
        @(negedge clk);
        in_valid   = 1'b0;
        in_state   = rand_state();
        in_inverse = ~inv;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("out_valid_after_transfer", out_valid, 1'b0);
        check_bit("in_ready_after_transfer", in_ready, 1'b1);
    endtask

    task automatic run_state(input string tag, input logic [127:0] s, input logic inv,
                             input logic [127:0] exp);
        int n;
        accept(s, inv);
        check_bit({tag, "_busy"}, busy, 1'b1);
        wait_out(n);
        check_int({tag, "_latency"}, n, NB);
        check_word({tag, "_result"}, out_state, exp);
        drain();
    endtask

    initial begin
        logic [127:0] s, exp, held;
        int n;

        rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_state = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_inverse = 1'b0; w_in_state = '0; w_out_ready = 1'b0;
        @(negedge clk);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_word("reset_out_state", out_state, '0);
        rst = 1'b0;
        @(negedge clk);

        // Known AES MixColumns vectors
        s   = 128'h2d26314c_01010101_f20a225c_db135345;
        exp = 128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc;
        check_word("model_fwd_vector", ref_mix(s, 1'b0), exp);
        run_state("fwd_vector", s, 1'b0, exp);

        // Reset two cycles into CALC discards the partial result
        accept(rand_state(), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_bit("midcalc_rst_out_valid", out_valid, 1'b0);
        check_bit("midcalc_rst_in_ready", in_ready, 1'b1);
        check_word("midcalc_rst_out_state", out_state, '0);
        @(negedge clk);
        rst = 1'b0;
        s = rand_state();
        run_state("after_reset", s, 1'b0, ref_mix(s, 1'b0));

        // Inverse mode on a single known column
        s   = 128'h0_8e4da1bc;
        exp = ref_mix(s, INV_EN);
        if (INV_EN) check_word("model_inv_vector", exp[31:0], 128'hdb135345);
        run_state("inv_vector", s, 1'b1, exp);

        // Random states and modes
        for (int i = 0; i < 8; i++) begin
            logic inv;
            s   = rand_state();
            inv = 1'($urandom_range(1));
            run_state("random", s, inv, ref_mix(s, inv & INV_EN));
        end

        // Backpressure: result held, second request not captured
        s   = rand_state();
        exp = ref_mix(s, 1'b0);
        accept(s, 1'b0);
        wait_out(n);
        check_int("bp_latency", n, NB);
        held = rand_state();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_state = held;
            @(negedge clk);
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_word("bp_out_state", out_state, exp);
        end
        in_valid = 1'b0;
        drain();
        check_word("bp_no_capture", out_state, exp);

        // out_ready already high: exactly one DONE cycle
        s = rand_state();
        out_ready = 1'b1;
        accept(s, 1'b0);
        wait_out(n);
        check_int("early_ready_latency", n, NB);
        check_word("early_ready_result", out_state, ref_mix(s, 1'b0));
        @(negedge clk);
        check_bit("early_ready_single", out_valid, 1'b0);
        check_bit("early_ready_idle", in_ready, 1'b1);
        out_ready = 1'b0;

        // LANES == NB: single CALC cycle
        s = {rand_state() >> 64};
        s[63:0] = 64'hd4d4d4d5_c6c6c6c6;
        exp = ref_mix(s, 1'b0);
        check_word("model_wide_vector", exp[63:0], 128'hd5d5d7d6_c6c6c6c6);
        check_bit("wide_in_ready", w_in_ready, 1'b1);
        w_in_valid = 1'b1;
        w_in_state = s;
        @(negedge clk);
        w_in_valid = 1'b0;
        w_in_state = '0;
        n = 0;
        while (w_out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_int("wide_latency", n, 1);
        check_word("wide_result", w_out_state, exp);
        w_out_ready = 1'b1;
        @(negedge clk);
        check_bit("wide_out_valid_drop", w_out_valid, 1'b0);
        w_out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
